regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-ported register file: NRD combinational read ports with write-through
// forwarding, two byte-enabled write ports, and a per-register busy
// scoreboard with a registered population count.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NRD      = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [DATA_W/8-1:0]   wbe0,
    input  logic [DATA_W-1:0]     wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [DATA_W/8-1:0]   wbe1,
    input  logic [DATA_W-1:0]     wdata1,
    input  logic                  iss_valid,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr0_act, wr1_act;

    // A write with no byte enables set touches neither data nor busy state.
    assign wr0_act = we0 && (|wbe0);
    assign wr1_act = we1 && (|wbe1);

    // Post-write register image; port 1 wins on lanes enabled by both ports.
    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (!(ZERO_REG != 0 && i == 0)) begin
                for (int b = 0; b < NB; b++) begin
                    if (we1 && waddr1 == ADDR_W'(i) && wbe1[b]) begin
                        mem_d[i][b*8 +: 8] = wdata1[b*8 +: 8];
                    end else if (we0 && waddr0 == ADDR_W'(i) && wbe0[b]) begin
                        mem_d[i][b*8 +: 8] = wdata0[b*8 +: 8];
                    end
                end
            end
        end
    end

    // Scoreboard next state: writes clear, issue sets, set wins a collision.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((wr0_act && waddr0 == ADDR_W'(i)) || (wr1_act && waddr1 == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (iss_valid && iss_addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                busy_d[i] = 1'b1;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Read ports: forwarded data, registered busy; zero in reset and for r0.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int k = 0; k < NRD; k++) begin
            logic [ADDR_W-1:0] ra;
            ra = raddr[k*ADDR_W +: ADDR_W];
            if (rst_n && !(ZERO_REG != 0 && ra == '0)) begin
                rdata[k*DATA_W +: DATA_W] = mem_d[ra];
                rbusy[k]                  = busy_q[ra];
            end
        end
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with default parameters.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  raddr = '0;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic [4:0]  waddr0 = '0, waddr1 = '0;
    logic [3:0]  wbe0 = '0, wbe1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [5:0]  busy_cnt;

    int ncmp = 0;
    int nerr = 0;

    regfile_mp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we0       (we0),
        .waddr0    (waddr0),
        .wbe0      (wbe0),
        .wdata0    (wdata0),
        .we1       (we1),
        .waddr1    (waddr1),
        .wbe1      (wbe1),
        .wdata1    (wdata1),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy_cnt  (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; wbe0 = '0; wbe1 = '0;
        iss_valid = 1'b0;
    endtask

    initial begin
        // Reset state, and activity during reset is ignored.
        #1;
        check("rst_rdata", rdata[31:0], 32'h0);
        check("rst_cnt", 32'(busy_cnt), 32'd0);
        we0 = 1'b1; waddr0 = 5'd5; wbe0 = 4'hF; wdata0 = 32'hDEAD_BEEF;
        iss_valid = 1'b1; iss_addr = 5'd5; raddr[4:0] = 5'd5;
        #1;
        check("rst_fwd_blocked", rdata[31:0], 32'h0);
        check("rst_rbusy", 32'(rbusy), 32'd0);
        tick();
        check("rst_cnt_after_edge", 32'(busy_cnt), 32'd0);
        idle();
        rst_n = 1'b1;
        #1;
        check("rst_write_lost", rdata[31:0], 32'h0);
        check("rst_issue_lost", 32'(rbusy), 32'd0);

        // Write-through forwarding on port 0.
        tick();
        we0 = 1'b1; waddr0 = 5'd5; wbe0 = 4'hF; wdata0 = 32'h1234_5678;
        #1;
        check("fwd_comb", rdata[31:0], 32'h1234_5678);
        tick();
        idle();
        #1;
        check("fwd_after_edge", rdata[31:0], 32'h1234_5678);

        // Byte-lane merge of both ports on one register.
        we1 = 1'b1; waddr1 = 5'd7; wbe1 = 4'hF; wdata1 = 32'hAABB_CCDD;
        tick();
        idle();
        raddr[9:5] = 5'd7;
        #1;
        check("r7_init", rdata[63:32], 32'hAABB_CCDD);
        we0 = 1'b1; waddr0 = 5'd7; wbe0 = 4'b0011; wdata0 = 32'h0000_1111;
        we1 = 1'b1; waddr1 = 5'd7; wbe1 = 4'b0110; wdata1 = 32'h0022_2200;
        #1;
        check("merge_comb", rdata[63:32], 32'hAA22_2211);
        tick();
        idle();
        #1;
        check("merge_reg", rdata[63:32], 32'hAA22_2211);

        // Register 0 is hardwired to zero and never busy.
        we0 = 1'b1; waddr0 = 5'd0; wbe0 = 4'hF; wdata0 = 32'hFFFF_FFFF;
        iss_valid = 1'b1; iss_addr = 5'd0; raddr[4:0] = 5'd0;
        #1;
        check("r0_comb", rdata[31:0], 32'h0);
        tick();
        idle();
        #1;
        check("r0_rdata", rdata[31:0], 32'h0);
        check("r0_rbusy", 32'(rbusy[0]), 32'd0);
        check("r0_cnt", 32'(busy_cnt), 32'd0);

        // Scoreboard: issue/write sequencing and set-wins collision.
        iss_valid = 1'b1; iss_addr = 5'd3;
        tick();
        check("sb_cnt1", 32'(busy_cnt), 32'd1);
        iss_addr = 5'd9;
        tick();
        check("sb_cnt2", 32'(busy_cnt), 32'd2);
        iss_addr = 5'd3;
        we0 = 1'b1; waddr0 = 5'd3; wbe0 = 4'hF; wdata0 = 32'h0000_0033;
        tick();
        check("sb_collide_cnt", 32'(busy_cnt), 32'd2);
        idle();
        we1 = 1'b1; waddr1 = 5'd9; wbe1 = 4'hF; wdata1 = 32'h0000_0099;
        raddr = {5'd9, 5'd3};
        #1;
        check("sb_rbusy_not_fwd", 32'(rbusy), 32'b11);
        check("sb_r9_fwd", rdata[63:32], 32'h0000_0099);
        tick();
        idle();
        #1;
        check("sb_cnt_final", 32'(busy_cnt), 32'd1);
        check("sb_rbusy_final", 32'(rbusy), 32'b01);

        // Write with all byte enables clear is a no-op.
        we0 = 1'b1; waddr0 = 5'd3; wbe0 = 4'h0; wdata0 = 32'hDEAD_BEEF;
        #1;
        check("nop_comb", rdata[31:0], 32'h0000_0033);
        tick();
        idle();
        #1;
        check("nop_data", rdata[31:0], 32'h0000_0033);
        check("nop_busy", 32'(rbusy[0]), 32'd1);
        check("nop_cnt", 32'(busy_cnt), 32'd1);

        // Two writes clear two busy bits in one edge.
        iss_valid = 1'b1; iss_addr = 5'd10;
        tick();
        iss_addr = 5'd11;
        tick();
        idle();
        check("dual_pre_cnt", 32'(busy_cnt), 32'd3);
        we0 = 1'b1; waddr0 = 5'd10; wbe0 = 4'hF; wdata0 = 32'h0000_00A0;
        we1 = 1'b1; waddr1 = 5'd11; wbe1 = 4'hF; wdata1 = 32'h0000_00B0;
        tick();
        idle();
        check("dual_clear_cnt", 32'(busy_cnt), 32'd1);

        // Load r1..r4 nonzero and busy, then reset asynchronously mid-cycle.
        for (int i = 1; i <= 4; i++) begin
            we0 = 1'b1; waddr0 = 5'(i); wbe0 = 4'hF; wdata0 = 32'h1000_0000 + 32'(i);
            iss_valid = 1'b1; iss_addr = 5'(i);
            tick();
        end
        idle();
        raddr = {5'd4, 5'd1};
        #1;
        check("load_cnt", 32'(busy_cnt), 32'd4);
        check("load_r4", rdata[63:32], 32'h1000_0004);
        check("load_rbusy", 32'(rbusy), 32'b11);
        we0 = 1'b1; waddr0 = 5'd5; wbe0 = 4'hF; wdata0 = 32'h5555_5555;
        iss_valid = 1'b1; iss_addr = 5'd6;
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_r1", rdata[31:0], 32'h0);
        check("arst_r4", rdata[63:32], 32'h0);
        check("arst_rbusy", 32'(rbusy), 32'd0);
        check("arst_cnt", 32'(busy_cnt), 32'd0);
        raddr = {5'd3, 5'd2};
        #1;
        check("arst_r2", rdata[31:0], 32'h0);
        check("arst_r3", rdata[63:32], 32'h0);
        tick();
        idle();
        rst_n = 1'b1;
        we0 = 1'b1; waddr0 = 5'd1; wbe0 = 4'hF; wdata0 = 32'hCAFE_F00D;
        iss_valid = 1'b1; iss_addr = 5'd2;
        tick();
        idle();
        raddr = {5'd2, 5'd1};
        #1;
        check("post_rst_write", rdata[31:0], 32'hCAFE_F00D);
        check("post_rst_r2", rdata[63:32], 32'h0);
        check("post_rst_rbusy", 32'(rbusy), 32'b10);
        check("post_rst_cnt", 32'(busy_cnt), 32'd1);
        raddr = {5'd6, 5'd5};
        #1;
        check("pending_write_lost", rdata[31:0], 32'h0);
        check("pending_issue_lost", 32'(rbusy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
